// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the 32 x 64-bit register file.
// Grants one of two valid/ready requesters per cycle, drops writes to r0, counts commits.
module regfile_write_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WEn,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] Write_data,
    output logic [CNT_W-1:0]  write_count
);

    logic              prio_r;
    logic              wen_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  count_r;

    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic              commit_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    // Grant decode: readys are forced low during reset so a handshake on the reset edge never happens.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n && !hold) begin
            if (req0_valid && (!req1_valid || !prio_r)) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
        end else begin
            grant1_s = 1'b0;
        end
    end

    // Winner's address/data and whether the accepted write reaches the register file.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (grant1_s) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
        accept_s = grant0_s | grant1_s;
        commit_s = accept_s && !(DISCARD_R0 && (sel_addr_s == {ADDR_W{1'b0}}));
    end

    // Priority pointer, write-port output registers and commit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r  <= 1'b0;
            wen_r   <= 1'b0;
            waddr_r <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                prio_r <= grant0_s;
            end else begin
                prio_r <= prio_r;
            end
            wen_r <= commit_s;
            if (commit_s) begin
                waddr_r <= sel_addr_s;
                wdata_r <= sel_data_s;
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
                count_r <= count_r;
            end
        end
    end

    assign req0_ready     = grant0_s;
    assign req1_ready     = grant1_s;
    assign WEn            = wen_r;
    assign write_register = waddr_r;
    assign Write_data     = wdata_r;
    assign write_count    = count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: default instance plus a CNT_W=4, DISCARD_R0=0 instance on shared inputs.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        WEn;
    logic [4:0]  write_register;
    logic [63:0] Write_data;
    logic [15:0] write_count;

    logic        b_req0_ready;
    logic        b_req1_ready;
    logic        b_WEn;
    logic [4:0]  b_write_register;
    logic [63:0] b_Write_data;
    logic [3:0]  b_write_count;

    logic [63:0] rf [32];

    int total;
    int bad;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .WEn(WEn), .write_register(write_register), .Write_data(Write_data), .write_count(write_count)
    );

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .CNT_W(4), .DISCARD_R0(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(b_req1_ready),
        .WEn(b_WEn), .write_register(b_write_register), .Write_data(b_Write_data), .write_count(b_write_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: captures the write port on the edge after WEn is presented.
    always @(posedge clk) begin
        if (WEn) rf[write_register] <= Write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        hold = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 64'h44;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h99;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
            end
            tick();
            total++;
            if (WEn !== 1'b0 || write_register !== 5'd0 || Write_data !== 64'd0 || write_count !== 16'd0) begin
                bad++; $display("FAIL reset_outputs got wen=%b reg=%0d data=%h cnt=%0d want 0 0 0 0",
                                WEn, write_register, Write_data, write_count);
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_first_grant got %b%b want 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h6;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready got %b want 1", req0_ready);
        end
        tick();
        total++;
        if (WEn !== 1'b1 || write_register !== 5'd5 || Write_data !== 64'h6 || write_count !== 16'd1) begin
            bad++; $display("FAIL single_w1 got wen=%b reg=%0d data=%h cnt=%0d want 1 5 6 1",
                            WEn, write_register, Write_data, write_count);
        end
        req0_addr = 5'd3; req0_data = 64'hABCDFE;
        tick();
        total++;
        if (WEn !== 1'b1 || write_register !== 5'd3 || Write_data !== 64'hABCDFE || write_count !== 16'd2) begin
            bad++; $display("FAIL single_w2 got wen=%b reg=%0d data=%h cnt=%0d want 1 3 abcdfe 2",
                            WEn, write_register, Write_data, write_count);
        end
        req0_valid = 1'b0;
        tick();
        total++;
        if (WEn !== 1'b0 || write_register !== 5'd3 || Write_data !== 64'hABCDFE || write_count !== 16'd2) begin
            bad++; $display("FAIL single_idle got wen=%b reg=%0d data=%h cnt=%0d want 0 3 abcdfe 2",
                            WEn, write_register, Write_data, write_count);
        end
        total++;
        if (rf[5] !== 64'h6 || rf[3] !== 64'hABCDFE) begin
            bad++; $display("FAIL single_rf got r5=%h r3=%h want 6 abcdfe", rf[5], rf[3]);
        end
    endtask

    task automatic test_contention();
        logic [4:0] i0;
        logic [4:0] i1;
        logic [4:0] exp_reg [4];
        logic [63:0] exp_dat [4];
        logic       exp_g [4];
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
        exp_reg[0] = 5'd1;  exp_dat[0] = 64'd101;
        exp_reg[1] = 5'd10; exp_dat[1] = 64'd210;
        exp_reg[2] = 5'd2;  exp_dat[2] = 64'd102;
        exp_reg[3] = 5'd11; exp_dat[3] = 64'd211;
        do_reset();
        i0 = 5'd1;
        i1 = 5'd10;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_addr = i0; req0_data = 64'd100 + 64'(i0);
            req1_valid = 1'b1; req1_addr = i1; req1_data = 64'd200 + 64'(i1);
            #1;
            total++;
            if (req0_ready !== !exp_g[k] || req1_ready !== exp_g[k]) begin
                bad++; $display("FAIL contention_grant%0d got %b%b want %b%b", k, req0_ready, req1_ready,
                                !exp_g[k], exp_g[k]);
            end
            tick();
            total++;
            if (WEn !== 1'b1 || write_register !== exp_reg[k] || Write_data !== exp_dat[k]) begin
                bad++; $display("FAIL contention_write%0d got wen=%b reg=%0d data=%0d want 1 %0d %0d", k,
                                WEn, write_register, Write_data, exp_reg[k], exp_dat[k]);
            end
            if (exp_g[k]) i1 = i1 + 5'd1;
            else i0 = i0 + 5'd1;
        end
        total++;
        if (write_count !== 16'd4) begin
            bad++; $display("FAIL contention_count got %0d want 4", write_count);
        end
    endtask

    task automatic test_hold();
        req0_valid = 1'b1; req0_addr = 5'd3;  req0_data = 64'd103;
        req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 64'd212;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++; $display("FAIL hold_ready%0d got %b%b want 00", c, req0_ready, req1_ready);
            end
            tick();
            total++;
            if (WEn !== 1'b0 || write_count !== 16'd4) begin
                bad++; $display("FAIL hold_wen%0d got wen=%b cnt=%0d want 0 4", c, WEn, write_count);
            end
        end
        hold = 1'b0;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL hold_release_grant got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        total++;
        if (WEn !== 1'b1 || write_register !== 5'd3 || write_count !== 16'd5) begin
            bad++; $display("FAIL hold_release_write got wen=%b reg=%0d cnt=%0d want 1 3 5",
                            WEn, write_register, write_count);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reg0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'd26;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL r0_ready got %b want 1", req1_ready);
        end
        tick();
        total++;
        if (WEn !== 1'b0 || write_count !== 16'd5) begin
            bad++; $display("FAIL r0_discard got wen=%b cnt=%0d want 0 5", WEn, write_count);
        end
        total++;
        if (b_WEn !== 1'b1 || b_write_register !== 5'd0 || b_Write_data !== 64'd26) begin
            bad++; $display("FAIL r0_nodiscard got wen=%b reg=%0d data=%0d want 1 0 26",
                            b_WEn, b_write_register, b_Write_data);
        end
        req1_addr = 5'd7;
        tick();
        total++;
        if (WEn !== 1'b1 || write_register !== 5'd7 || Write_data !== 64'd26 || write_count !== 16'd6) begin
            bad++; $display("FAIL r7_write got wen=%b reg=%0d data=%0d cnt=%0d want 1 7 26 6",
                            WEn, write_register, Write_data, write_count);
        end
        total++;
        if (b_write_count !== 4'd7) begin
            bad++; $display("FAIL r0_nodiscard_count got %0d want 7", b_write_count);
        end
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'd99;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_ready_before got %b want 1", req0_ready);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (WEn !== 1'b0 || write_count !== 16'd0 || b_write_count !== 4'd0) begin
            bad++; $display("FAIL midrst_edge got wen=%b cnt=%0d cnt_b=%0d want 0 0 0", WEn, write_count, b_write_count);
        end
        rst_n = 1'b1;
        req0_valid = 1'b0;
        tick();
        total++;
        if (WEn !== 1'b0 || write_count !== 16'd0) begin
            bad++; $display("FAIL midrst_after got wen=%b cnt=%0d want 0 0", WEn, write_count);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int wen_bad;
        wen_bad = 0;
        req0_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            req0_addr = 5'(k % 31 + 1);
            req0_data = 64'(k);
            tick();
            if (WEn !== 1'b1) wen_bad++;
        end
        req0_valid = 1'b0;
        total++;
        if (wen_bad !== 0) begin
            bad++; $display("FAIL b2b_wen got %0d idle cycles want 0", wen_bad);
        end
        total++;
        if (write_count !== 16'd17) begin
            bad++; $display("FAIL b2b_count got %0d want 17", write_count);
        end
        total++;
        if (b_write_count !== 4'd1) begin
            bad++; $display("FAIL wrap_count got %0d want 1", b_write_count);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        hold = 1'b0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 64'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 64'd0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_reg0();
        test_mid_reset();
        test_back_to_back_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
